// File: rtl/sirius_fwd_pkg.sv
// rtl/sirius_fwd_pkg.sv - shared defaults and scoreboard entry type for the forwarding scoreboard
package sirius_fwd_pkg;

  localparam int NUM_READ_DEF  = 4;
  localparam int NUM_STAGE_DEF = 4;
  localparam int MAX_LAT_DEF   = 15;
  localparam int SB_CNT_W      = $clog2(MAX_LAT_DEF + 1);
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                busy;
    logic [SB_CNT_W-1:0] cnt;
  } sb_entry_t;

endpackage

// File: rtl/fwd_port_mux.sv
// rtl/fwd_port_mux.sv - priority operand select for one read port
// The lowest-index matching stage wins; r0 is hardwired and never hazards.
module fwd_port_mux
  import sirius_fwd_pkg::*;
#(
  parameter int NUM_STAGE = NUM_STAGE_DEF
) (
  input  logic [NUM_STAGE-1:0]       stg_en,
  input  logic [NUM_STAGE-1:0][4:0]  stg_addr,
  input  logic [NUM_STAGE-1:0]       stg_valid,
  input  logic [NUM_STAGE-1:0][31:0] stg_data,
  input  logic [4:0]                 rd_addr,
  input  logic [31:0]                rd_regfile,
  input  logic                       busy,
  output logic [31:0]                rd_data,
  output logic                       hazard
);

  logic [31:0] sel_data;
  logic        load_use;

  // Walk from lowest priority up so the highest-priority match lands last.
  always_comb begin
    sel_data = rd_regfile;
    load_use = 1'b0;
    for (int i = NUM_STAGE - 1; i >= 0; i--) begin
      if (stg_en[i] && stg_addr[i] == rd_addr) begin
        sel_data = stg_data[i];
        load_use = ~stg_valid[i];
      end
    end
  end

  always_comb begin
    rd_data = sel_data;
    hazard  = load_use | busy;
    if (rd_addr == REG_ZERO) begin
      rd_data = 32'd0;
      hazard  = 1'b0;
    end
  end

endmodule

// File: rtl/forwarding_scoreboard.sv
// rtl/forwarding_scoreboard.sv - operand forwarding with multi-cycle scoreboard and stall counter
// Stage forwarding is purely combinational; the scoreboard tracks in-flight MUL/DIV/CP0 results.
module forwarding_scoreboard
  import sirius_fwd_pkg::*;
#(
  parameter int NUM_READ  = NUM_READ_DEF,
  parameter int NUM_STAGE = NUM_STAGE_DEF,
  parameter int MAX_LAT   = MAX_LAT_DEF,
  parameter int CNT_W     = $clog2(MAX_LAT + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_STAGE-1:0]       stg_en,
  input  logic [NUM_STAGE-1:0][4:0]  stg_addr,
  input  logic [NUM_STAGE-1:0]       stg_valid,
  input  logic [NUM_STAGE-1:0][31:0] stg_data,
  input  logic [NUM_READ-1:0][4:0]   rd_addr,
  input  logic [NUM_READ-1:0][31:0]  rd_regfile,
  output logic [NUM_READ-1:0][31:0]  rd_data,
  input  logic                       iss_valid,
  input  logic [4:0]                 iss_addr,
  input  logic [CNT_W-1:0]           iss_lat,
  input  logic                       wb_valid,
  input  logic [4:0]                 wb_addr,
  input  logic                       flush,
  output logic                       stall,
  output logic [31:0]                stall_cnt
);

  sb_entry_t          sb [32];
  logic [31:0]        busy_vec;
  logic [NUM_READ-1:0] hazard;
  logic [31:0]        stall_cnt_q;

  always_comb begin
    busy_vec = '0;
    for (int e = 0; e < 32; e++) begin
      busy_vec[e] = sb[e].busy;
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_port
    fwd_port_mux #(.NUM_STAGE(NUM_STAGE)) u_mux (
      .stg_en     (stg_en),
      .stg_addr   (stg_addr),
      .stg_valid  (stg_valid),
      .stg_data   (stg_data),
      .rd_addr    (rd_addr[p]),
      .rd_regfile (rd_regfile[p]),
      .busy       (busy_vec[rd_addr[p]]),
      .rd_data    (rd_data[p]),
      .hazard     (hazard[p])
    );
  end

  assign stall = |hazard;

  // Flush beats issue, issue beats writeback; idle busy entries count down to zero and wait for wb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < 32; e++) begin
        sb[e] <= '0;
      end
    end else begin
      for (int e = 0; e < 32; e++) begin
        if (flush) begin
          sb[e] <= '0;
        end else if (iss_valid && iss_addr != REG_ZERO && iss_addr == 5'(e)) begin
          sb[e].busy <= 1'b1;
          sb[e].cnt  <= iss_lat;
        end else if (wb_valid && wb_addr == 5'(e)) begin
          sb[e] <= '0;
        end else if (sb[e].busy && sb[e].cnt != '0) begin
          sb[e].cnt <= sb[e].cnt - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
    end else if (stall && stall_cnt_q != 32'hFFFF_FFFF) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// tb/tb_forwarding_scoreboard.sv - randomized self-checking bench for forwarding_scoreboard
module tb_forwarding_scoreboard;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       stg_en;
  logic [3:0][4:0]  stg_addr;
  logic [3:0]       stg_valid;
  logic [3:0][31:0] stg_data;
  logic [3:0][4:0]  rd_addr;
  logic [3:0][31:0] rd_regfile;
  logic [3:0][31:0] rd_data;
  logic             iss_valid;
  logic [4:0]       iss_addr;
  logic [3:0]       iss_lat;
  logic             wb_valid;
  logic [4:0]       wb_addr;
  logic             flush;
  logic             stall;
  logic [31:0]      stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] mbusy;
  logic [31:0] mscnt;

  forwarding_scoreboard dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stg_en     (stg_en),
    .stg_addr   (stg_addr),
    .stg_valid  (stg_valid),
    .stg_data   (stg_data),
    .rd_addr    (rd_addr),
    .rd_regfile (rd_regfile),
    .rd_data    (rd_data),
    .iss_valid  (iss_valid),
    .iss_addr   (iss_addr),
    .iss_lat    (iss_lat),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .flush      (flush),
    .stall      (stall),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_data(int p);
    if (rd_addr[p] == 5'd0) return 32'd0;
    for (int i = 0; i < 4; i++)
      if (stg_en[i] && stg_addr[i] == rd_addr[p]) return stg_data[i];
    return rd_regfile[p];
  endfunction

  function automatic logic exp_hazard(int p);
    if (rd_addr[p] == 5'd0) return 1'b0;
    if (mbusy[rd_addr[p]]) return 1'b1;
    for (int i = 0; i < 4; i++)
      if (stg_en[i] && stg_addr[i] == rd_addr[p]) return ~stg_valid[i];
    return 1'b0;
  endfunction

  function automatic logic exp_stall();
    logic s = 1'b0;
    for (int p = 0; p < 4; p++) s |= exp_hazard(p);
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mbusy = '0;
      mscnt = 32'd0;
    end else begin
      if (exp_stall() && mscnt != 32'hFFFF_FFFF) mscnt = mscnt + 32'd1;
      if (flush) begin
        mbusy = '0;
      end else begin
        if (wb_valid) mbusy[wb_addr] = 1'b0;
        if (iss_valid && iss_addr != 5'd0) mbusy[iss_addr] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    for (int p = 0; p < 4; p++)
      chk($sformatf("model_rd_data[%0d]", p), rd_data[p], exp_data(p));
    chk("model_stall", {31'd0, stall}, {31'd0, exp_stall()});
    chk("model_stall_cnt", stall_cnt, mscnt);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    stg_en = '0; stg_addr = '0; stg_valid = '1; stg_data = '0;
    rd_addr = '0; rd_regfile = '0;
    iss_valid = 1'b0; iss_addr = '0; iss_lat = '0;
    wb_valid = 1'b0; wb_addr = '0; flush = 1'b0;
  endtask

  initial begin
    clear_inputs();
    mbusy = '0;
    mscnt = 32'd0;
    rst_n = 1'b0;
    tick(2);
    #1 chk("reset_stall_cnt", stall_cnt, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    rst_n = 1'b1;
    tick(1);

    // Two stages write r5; the higher-priority one must win.
    stg_en = 4'b0101; stg_addr[0] = 5'd5; stg_addr[2] = 5'd5;
    stg_data[0] = 32'hAAAA; stg_data[2] = 32'hBBBB; rd_addr[0] = 5'd5;
    rd_regfile[0] = 32'hDEAD_BEEF;
    #1 chk("prio_rd_data", rd_data[0], 32'h0000_AAAA);
    chk("prio_stall", {31'd0, stall}, 32'd0);

    stg_en = 4'hF; stg_addr = '0; stg_data = {4{32'h1234}}; rd_addr = '0;
    rd_regfile = {4{32'h5555_5555}};
    #1 for (int p = 0; p < 4; p++) chk($sformatf("r0_rd_data[%0d]", p), rd_data[p], 32'd0);
    chk("r0_stall", {31'd0, stall}, 32'd0);
    tick(1);

    // Load-use on r7 held for three cycles.
    clear_inputs();
    stg_en = 4'b0010; stg_addr[1] = 5'd7; stg_valid = 4'b1101; rd_addr[2] = 5'd7;
    tick(3);
    #1 chk("load_use_stall", {31'd0, stall}, 32'd1);
    chk("load_use_stall_cnt", stall_cnt, 32'd3);
    clear_inputs();
    tick(1);

    // Multi-cycle r9: busy until wb, then clear the cycle after.
    iss_valid = 1'b1; iss_addr = 5'd9; iss_lat = 4'd3; rd_addr[1] = 5'd9;
    #1 chk("iss_cycle_no_stall", {31'd0, stall}, 32'd0);
    tick(1);
    iss_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("busy_r9_cycle%0d", k), {31'd0, stall}, 32'd1);
      tick(1);
    end
    wb_valid = 1'b1; wb_addr = 5'd9;
    #1 chk("wb_cycle_still_stall", {31'd0, stall}, 32'd1);
    tick(1);
    wb_valid = 1'b0;
    #1 chk("after_wb_no_stall", {31'd0, stall}, 32'd0);
    iss_valid = 1'b1; wb_valid = 1'b1;
    tick(1);
    iss_valid = 1'b0; wb_valid = 1'b0;
    #1 chk("iss_wb_same_busy", {31'd0, stall}, 32'd1);
    wb_valid = 1'b1;
    tick(1);
    wb_valid = 1'b0;
    #1 chk("iss_wb_cleared", {31'd0, stall}, 32'd0);

    // Flush and asynchronous reset drop pending r4.
    iss_valid = 1'b1; iss_addr = 5'd4; iss_lat = 4'd5; rd_addr[1] = 5'd4;
    tick(1);
    iss_valid = 1'b0;
    tick(2);
    flush = 1'b1;
    #1 chk("pre_flush_stall", {31'd0, stall}, 32'd1);
    tick(1);
    flush = 1'b0;
    #1 chk("post_flush_stall", {31'd0, stall}, 32'd0);
    iss_valid = 1'b1;
    tick(1);
    iss_valid = 1'b0;
    #1 chk("reissue_stall", {31'd0, stall}, 32'd1);
    rst_n = 1'b0;
    #1 chk("midrst_stall", {31'd0, stall}, 32'd0);
    chk("midrst_stall_cnt", stall_cnt, 32'd0);
    tick(1);
    rst_n = 1'b1;
    #1 chk("post_rst_no_wb", {31'd0, stall}, 32'd0);

    // Saturation of the stall counter.
    iss_valid = 1'b1;
    tick(1);
    iss_valid = 1'b0;
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    mscnt = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt_q;
    tick(3);
    #1 chk("sat_stall_cnt", stall_cnt, 32'hFFFF_FFFF);
    wb_valid = 1'b1; wb_addr = 5'd4;
    tick(1);
    clear_inputs();
    tick(1);

    // Random traffic on a narrow register range to force collisions.
    for (int n = 0; n < 500; n++) begin
      rst_n     = ($urandom_range(0, 59) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      stg_en    = 4'($urandom);
      stg_valid = 4'($urandom) | 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        stg_addr[i]   = 5'($urandom_range(0, 7));
        stg_data[i]   = $urandom;
        rd_addr[i]    = 5'($urandom_range(0, 7));
        rd_regfile[i] = $urandom;
      end
      iss_valid = ($urandom_range(0, 3) == 0);
      iss_addr  = 5'($urandom_range(0, 7));
      iss_lat   = 4'($urandom_range(0, 15));
      wb_valid  = ($urandom_range(0, 2) == 0);
      wb_addr   = 5'($urandom_range(0, 7));
      tick(1);
    end
    rst_n = 1'b1;
    clear_inputs();
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
